// File: rtl/fib_result_checker.sv
// Store-snooping monitor: checks that DM words 0..NUM_TERMS-1 are written in
// order with Fibonacci values, and reports pass, first error, or timeout.
module fib_result_checker #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned NUM_TERMS = 10,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned F0        = 0,
    parameter int unsigned F1        = 1,
    parameter int unsigned TIMEOUT   = 400
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [1:0]        err_code,
    output logic [7:0]        err_index,
    output logic [DATA_W-1:0] err_expected,
    output logic [DATA_W-1:0] err_actual,
    output logic [7:0]        term_count
);

    localparam int unsigned     CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0] WIN_LO  = (ADDR_W + 1)'(BASE_ADDR);
    localparam logic [ADDR_W:0] WIN_HI  = WIN_LO + (ADDR_W + 1)'(4 * NUM_TERMS);
    localparam logic [DATA_W-1:0] EXP0  = DATA_W'(F0);
    localparam logic [DATA_W-1:0] EXP1  = DATA_W'(F1);
    localparam logic [7:0]      LAST_TC = 8'(NUM_TERMS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_VALUE = 2'd1;
    localparam logic [1:0] ERR_ORDER = 2'd2;
    localparam logic [1:0] ERR_TIME  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] exp_a, exp_a_n, exp_b, exp_b_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              busy_n, done_n, pass_n;
    logic [1:0]        err_code_n;
    logic [7:0]        err_index_n, term_count_n;
    logic [DATA_W-1:0] err_expected_n, err_actual_n;

    logic [ADDR_W-1:0] offs;
    logic [7:0]        idx;
    logic              in_window;

    // Window bounds compared one bit wider so BASE_ADDR+4*NUM_TERMS cannot wrap.
    assign offs      = dm_addr - ADDR_W'(BASE_ADDR);
    assign idx       = 8'(offs >> 2);
    assign in_window = dm_we && (dm_addr[1:0] == 2'b00)
                       && ({1'b0, dm_addr} >= WIN_LO) && ({1'b0, dm_addr} < WIN_HI);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_code     <= ERR_NONE;
            err_index    <= '0;
            err_expected <= '0;
            err_actual   <= '0;
            term_count   <= '0;
            exp_a        <= EXP0;
            exp_b        <= EXP1;
            cnt          <= '0;
        end else begin
            state        <= state_n;
            busy         <= busy_n;
            done         <= done_n;
            pass         <= pass_n;
            err_code     <= err_code_n;
            err_index    <= err_index_n;
            err_expected <= err_expected_n;
            err_actual   <= err_actual_n;
            term_count   <= term_count_n;
            exp_a        <= exp_a_n;
            exp_b        <= exp_b_n;
            cnt          <= cnt_n;
        end
    end

    always_comb begin
        state_n        = state;
        busy_n         = busy;
        done_n         = done;
        pass_n         = pass;
        err_code_n     = err_code;
        err_index_n    = err_index;
        err_expected_n = err_expected;
        err_actual_n   = err_actual;
        term_count_n   = term_count;
        exp_a_n        = exp_a;
        exp_b_n        = exp_b;
        cnt_n          = cnt;

        if (start) begin
            state_n        = S_ARMED;
            busy_n         = 1'b1;
            done_n         = 1'b0;
            pass_n         = 1'b0;
            err_code_n     = ERR_NONE;
            err_index_n    = '0;
            err_expected_n = '0;
            err_actual_n   = '0;
            term_count_n   = '0;
            exp_a_n        = EXP0;
            exp_b_n        = EXP1;
            cnt_n          = '0;
        end else if (state == S_ARMED) begin
            if (in_window) begin
                if (idx != term_count || dm_wdata != exp_a) begin
                    state_n        = S_FAIL;
                    busy_n         = 1'b0;
                    done_n         = 1'b1;
                    err_code_n     = (idx != term_count) ? ERR_ORDER : ERR_VALUE;
                    err_index_n    = idx;
                    err_expected_n = exp_a;
                    err_actual_n   = dm_wdata;
                end else begin
                    term_count_n = term_count + 8'd1;
                    exp_a_n      = exp_b;
                    exp_b_n      = exp_a + exp_b;
                    cnt_n        = '0;
                    if (term_count == LAST_TC) begin
                        state_n = S_PASS;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        pass_n  = 1'b1;
                    end
                end
            end else if (cnt == CNT_LAST) begin
                state_n        = S_TIMEOUT;
                busy_n         = 1'b0;
                done_n         = 1'b1;
                err_code_n     = ERR_TIME;
                err_index_n    = term_count;
                err_expected_n = exp_a;
                err_actual_n   = '0;
            end else begin
                cnt_n = cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fib_result_checker.sv
// Directed bench for fib_result_checker: default, short-timeout and 8-bit
// wrap configurations share one write bus, each armed by its own start.
module tb_fib_result_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;

    logic        busy0, done0, pass0;
    logic [1:0]  code0;
    logic [7:0]  eidx0, tc0;
    logic [31:0] eexp0, eact0;

    logic        busy1, done1, pass1;
    logic [1:0]  code1;
    logic [7:0]  eidx1, tc1;
    logic [31:0] eexp1, eact1;

    logic        busy2, done2, pass2;
    logic [1:0]  code2;
    logic [7:0]  eidx2, tc2;
    logic [7:0]  eexp2, eact2;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    int unsigned fib[14] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};

    always #5 clk = ~clk;

    fib_result_checker u0 (
        .clk(clk), .reset(reset), .start(start0), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .busy(busy0), .done(done0), .pass(pass0), .err_code(code0),
        .err_index(eidx0), .err_expected(eexp0), .err_actual(eact0), .term_count(tc0)
    );

    fib_result_checker #(.TIMEOUT(20)) u1 (
        .clk(clk), .reset(reset), .start(start1), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .busy(busy1), .done(done1), .pass(pass1), .err_code(code1),
        .err_index(eidx1), .err_expected(eexp1), .err_actual(eact1), .term_count(tc1)
    );

    fib_result_checker #(.DATA_W(8), .NUM_TERMS(14)) u2 (
        .clk(clk), .reset(reset), .start(start2), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata[7:0]), .busy(busy2), .done(done2), .pass(pass2), .err_code(code2),
        .err_index(eidx2), .err_expected(eexp2), .err_actual(eact2), .term_count(tc2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick(input int unsigned n = 1);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        dm_we = 1'b1; dm_addr = addr; dm_wdata = data;
        tick();
        dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    endtask

    task automatic pulse(input int unsigned which);
        case (which)
            0: start0 = 1'b1;
            1: start1 = 1'b1;
            default: start2 = 1'b1;
        endcase
        tick();
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    endtask

    initial begin
        // reset state
        #12;
        check("rst_busy", 32'(busy0), 0);
        check("rst_done", 32'(done0), 0);
        check("rst_pass", 32'(pass0), 0);
        check("rst_tc",   32'(tc0), 0);
        reset = 1'b1;
        tick();

        // golden run, one write every 8 cycles
        pulse(0);
        check("gold_busy", 32'(busy0), 1);
        for (int unsigned i = 0; i < 10; i++) begin
            wr(4 * i, fib[i]);
            if (i == 8) check("gold_notdone", 32'(done0), 0);
            tick(7);
        end
        check("gold_done", 32'(done0), 1);
        check("gold_pass", 32'(pass0), 1);
        check("gold_busy0", 32'(busy0), 0);
        check("gold_tc", 32'(tc0), 10);
        check("gold_code", 32'(code0), 0);

        // value mismatch at index 5
        pulse(0);
        for (int unsigned i = 0; i < 5; i++) wr(4 * i, fib[i]);
        check("mis_pre_done", 32'(done0), 0);
        wr(20, 6);
        check("mis_done", 32'(done0), 1);
        check("mis_pass", 32'(pass0), 0);
        check("mis_code", 32'(code0), 1);
        check("mis_idx", 32'(eidx0), 5);
        check("mis_exp", eexp0, 5);
        check("mis_act", eact0, 6);
        check("mis_tc", 32'(tc0), 5);
        wr(20, 5);
        wr(24, 8);
        check("mis_hold_code", 32'(code0), 1);
        check("mis_hold_act", eact0, 6);
        check("mis_hold_tc", 32'(tc0), 5);

        // order error: skip to index 3
        pulse(0);
        check("ord_clear_code", 32'(code0), 0);
        check("ord_clear_done", 32'(done0), 0);
        wr(0, 0);
        wr(4, 1);
        wr(12, 2);
        check("ord_code", 32'(code0), 2);
        check("ord_idx", 32'(eidx0), 3);
        check("ord_exp", eexp0, 1);
        check("ord_act", eact0, 2);
        check("ord_tc", 32'(tc0), 2);

        // rewrite of an earlier index is out-of-order
        pulse(0);
        wr(0, 0);
        wr(0, 0);
        check("rew_code", 32'(code0), 2);
        check("rew_idx", 32'(eidx0), 0);
        check("rew_exp", eexp0, 1);

        // write coincident with start is ignored; filtered writes interleaved
        start0 = 1'b1; dm_we = 1'b1; dm_addr = 32'd4; dm_wdata = 32'd1;
        tick();
        start0 = 1'b0; dm_we = 1'b0;
        check("flt_start_tc", 32'(tc0), 0);
        check("flt_start_done", 32'(done0), 0);
        for (int unsigned i = 0; i < 10; i++) begin
            wr(32'h100, 32'hdead);
            wr(32'h6, 32'hbeef);
            wr(32'd40, 32'h55);
            wr(4 * i, fib[i]);
        end
        check("flt_pass", 32'(pass0), 1);
        check("flt_code", 32'(code0), 0);
        check("flt_tc", 32'(tc0), 10);

        // timeout with TIMEOUT=20
        pulse(1);
        tick(19);
        check("to_early", 32'(done1), 0);
        tick();
        check("to_done", 32'(done1), 1);
        check("to_code", 32'(code1), 3);
        check("to_idx", 32'(eidx1), 0);
        check("to_exp", eexp1, 0);
        check("to_act", eact1, 0);

        // accepted write on the would-be timeout edge wins
        pulse(1);
        tick(19);
        wr(0, 0);
        check("tow_done", 32'(done1), 0);
        check("tow_tc", 32'(tc1), 1);
        tick(19);
        check("tow_early", 32'(done1), 0);
        tick();
        check("tow_done2", 32'(done1), 1);
        check("tow_idx", 32'(eidx1), 1);
        check("tow_exp", eexp1, 1);

        // 8-bit wrap, 14 terms back-to-back
        pulse(2);
        for (int unsigned i = 0; i < 14; i++) wr(4 * i, fib[i]);
        check("wrap_pass", 32'(pass2), 1);
        check("wrap_tc", 32'(tc2), 14);
        check("wrap_code", 32'(code2), 0);

        // restart from PASS
        pulse(2);
        check("rs_busy", 32'(busy2), 1);
        check("rs_done", 32'(done2), 0);
        check("rs_pass", 32'(pass2), 0);
        check("rs_tc", 32'(tc2), 0);

        // asynchronous reset mid-run
        for (int unsigned i = 0; i < 4; i++) wr(4 * i, fib[i]);
        check("ar_tc4", 32'(tc2), 4);
        #2 reset = 1'b0;
        #1;
        check("ar_busy", 32'(busy2), 0);
        check("ar_tc", 32'(tc2), 0);
        tick();
        reset = 1'b1;
        wr(0, 0);
        check("ar_idle_tc", 32'(tc2), 0);
        check("ar_idle_busy", 32'(busy2), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
